// File: rtl/sha_digest_writer.sv
// SHA-256 digest writer: queues {hash, chunk count} records and writes each
// to host memory as a single 512-bit AXI4 beat at consecutive 64-byte slots.
module sha_digest_writer #(
  parameter logic [15:0] AXI_ID    = 16'h0001,
  parameter int          LOG_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dig_valid,
  output logic         dig_ready,
  input  logic [255:0] dig_hash,
  input  logic [63:0]  dig_words,
  input  logic         cfg_load,
  input  logic [63:0]  cfg_base,
  output logic [15:0]  awid_m,
  output logic [63:0]  awaddr_m,
  output logic [7:0]   awlen_m,
  output logic [2:0]   awsize_m,
  output logic         awvalid_m,
  input  logic         awready_m,
  output logic [511:0] wdata_m,
  output logic [63:0]  wstrb_m,
  output logic         wlast_m,
  output logic         wvalid_m,
  input  logic         wready_m,
  input  logic [15:0]  bid_m,
  input  logic [1:0]   bresp_m,
  input  logic         bvalid_m,
  output logic         bready_m,
  output logic [63:0]  done_count,
  output logic [63:0]  err_count,
  output logic         busy
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int EW    = 320;
  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = 1;
  localparam logic [LOG_DEPTH:0]   CNT_ONE  = 1;
  localparam logic [LOG_DEPTH:0]   CNT_FULL = (LOG_DEPTH+1)'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT_B = 2'd2;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wptr_q, rptr_q;
  logic [LOG_DEPTH:0]   cnt_q, cnt_d;
  logic                 full_q;
  logic                 push, pop;

  logic [1:0]  state_q, state_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        aw_hs, w_hs, cfg_take;

  logic [63:0] base_q, done_q, err_q;
  logic [57:0] idx_q;

  // Entries are stored in beat order so the head maps straight onto wdata.
  assign push = dig_valid && !full_q;
  assign pop  = (state_q == S_WAIT_B) && bvalid_m;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {dig_words, dig_hash};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CNT_FULL);
    end
  end

  assign aw_hs = awvalid_q && awready_m;
  assign w_hs  = wvalid_q && wready_m;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          state_d   = S_ISSUE;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        // AW and W complete independently; leave only once both have.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (bvalid_m) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Reconfiguration only while fully idle, so no B response can race it.
  assign cfg_take = cfg_load && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      idx_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
    end else if (cfg_take) begin
      base_q <= cfg_base;
      idx_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
    end else if (pop) begin
      idx_q  <= idx_q + 58'd1;
      done_q <= done_q + 64'd1;
      err_q  <= err_q + {63'd0, |bresp_m};
    end
  end

  assign dig_ready  = !full_q;
  assign busy       = (cnt_q != '0) || (state_q != S_IDLE);
  assign awid_m     = AXI_ID;
  assign awaddr_m   = {base_q[63:6], 6'b0} + {idx_q, 6'b0};
  assign awlen_m    = 8'd0;
  assign awsize_m   = 3'b110;
  assign awvalid_m  = awvalid_q;
  assign wdata_m    = {192'd0, mem_q[rptr_q]};
  assign wstrb_m    = '1;
  assign wlast_m    = 1'b1;
  assign wvalid_m   = wvalid_q;
  assign bready_m   = (state_q == S_WAIT_B);
  assign done_count = done_q;
  assign err_count  = err_q;

  logic unused_ok;
  assign unused_ok = ^bid_m;
endmodule
